// File: rtl/tx_port_if.sv
// Link-side bundle for tx_port: local FIFO pop side, downstream flit link and credit return.
interface tx_port_if #(
  parameter int DATAW = 31,
  parameter int CNTW  = 3
);
  logic [DATAW:0]  fifo_data;
  logic            fifo_empty;
  logic            fifo_rd_en;
  logic [DATAW:0]  odata;
  logic            ovalid;
  logic            icredit;
  logic [CNTW-1:0] credits;
  logic            in_pkt;

  // master: the transmit port itself; slave: FIFO/link environment around it
  modport master (
    input  fifo_data, fifo_empty, icredit,
    output fifo_rd_en, odata, ovalid, credits, in_pkt
  );
  modport slave (
    output fifo_data, fifo_empty, icredit,
    input  fifo_rd_en, odata, ovalid, credits, in_pkt
  );
endinterface

// File: rtl/tx_port.sv
// Credit-based flit transmit port with packet-framing FSM.
// Optional macro TX_CREDIT_CHECK_EN adds sticky error output cerr.
module tx_port #(
  parameter int DATAW = 31,
  parameter int CRED  = 4,
  parameter int CNTW  = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef TX_CREDIT_CHECK_EN
  output logic        cerr,
`endif
  tx_port_if.master   bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;
  localparam logic [CNTW-1:0] CRED_MAX = CNTW'(CRED);

  state_t          state;
  logic            send;
  logic            cred_inc;
  logic            cred_full;
  logic [1:0]      ftype;
  logic [CNTW-1:0] credits_nxt;

  assign ftype     = bus.fifo_data[DATAW:DATAW-1];
  assign cred_full = (bus.credits == CRED_MAX);
  // Reset blocks popping so nothing leaves the FIFO while the port is being cleared
  assign send      = ~rst & ~bus.fifo_empty & (bus.credits != '0);
  assign bus.fifo_rd_en = send;

  // A credit returned while full and not sending has nowhere to go: drop it
  assign cred_inc    = bus.icredit & ~(cred_full & ~send);
  assign credits_nxt = bus.credits + CNTW'(cred_inc) - CNTW'(send);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.credits <= CRED_MAX;
      bus.odata   <= '0;
      bus.ovalid  <= 1'b0;
      bus.in_pkt  <= 1'b0;
      state       <= IDLE;
    end else begin
      bus.credits <= credits_nxt;
      bus.ovalid  <= send;
      bus.odata   <= send ? bus.fifo_data : '0;
      if (send) begin
        // Next state follows the flit type alone, even for out-of-order flits
        unique case (ftype)
          T_HEAD: begin state <= ACTIVE; bus.in_pkt <= 1'b1; end
          T_TAIL,
          T_HT:   begin state <= IDLE;   bus.in_pkt <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

`ifdef TX_CREDIT_CHECK_EN
  logic proto_err;

  always_comb begin
    proto_err = 1'b0;
    if (send) begin
      if (state == IDLE)
        proto_err = (ftype == T_BODY) || (ftype == T_TAIL);
      else
        proto_err = (ftype == T_HEAD) || (ftype == T_HT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cerr <= 1'b0;
    else if (proto_err || (bus.icredit && cred_full && !send))
      cerr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tx_port.sv
// Directed bench for tx_port: reset, packet stream, credit starvation/return,
// credit saturation and mid-packet reset.
module tb_tx_port;

  localparam int DATAW = 31;
  localparam int CRED  = 4;
  localparam int CNTW  = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  tx_port_if #(.DATAW(DATAW), .CNTW(CNTW)) bus ();

`ifdef TX_CREDIT_CHECK_EN
  logic cerr;
`endif

  tx_port #(.DATAW(DATAW), .CRED(CRED), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
`ifdef TX_CREDIT_CHECK_EN
    .cerr(cerr),
`endif
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] H  = {2'b01, 30'h0000_0A1};
  localparam logic [31:0] B1 = {2'b00, 30'h0000_0B2};
  localparam logic [31:0] B2 = {2'b00, 30'h0000_0B3};
  localparam logic [31:0] T  = {2'b10, 30'h0000_0C4};
  localparam logic [31:0] HT = {2'b11, 30'h0000_0D5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;

    // Reset with a non-empty FIFO: nothing may be popped
    rst = 1'b1;
    bus.fifo_empty = 1'b0;
    bus.fifo_data  = H;
    bus.icredit    = 1'b0;
    #1;
    check("rst_rd_en_comb", 32'(bus.fifo_rd_en), 32'd0);
    tick(); tick();
    check("rst_credits", 32'(bus.credits), 32'd4);
    check("rst_ovalid",  32'(bus.ovalid),  32'd0);
    check("rst_odata",   bus.odata,        32'd0);
    check("rst_in_pkt",  32'(bus.in_pkt),  32'd0);
    check("rst_rd_en",   32'(bus.fifo_rd_en), 32'd0);
`ifdef TX_CREDIT_CHECK_EN
    check("rst_cerr", 32'(cerr), 32'd0);
`endif

    // Head, body, body, tail streamed back to back, credits 4 -> 0
    rst = 1'b0;
    bus.fifo_data = H;
    #1;
    check("pkt_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    tick();
    check("pkt_h_valid", 32'(bus.ovalid), 32'd1);
    check("pkt_h_data",  bus.odata,       H);
    check("pkt_h_cred",  32'(bus.credits), 32'd3);
    check("pkt_h_inpkt", 32'(bus.in_pkt),  32'd1);
    bus.fifo_data = B1;
    tick();
    check("pkt_b1_data",  bus.odata,        B1);
    check("pkt_b1_cred",  32'(bus.credits), 32'd2);
    check("pkt_b1_inpkt", 32'(bus.in_pkt),  32'd1);
    bus.fifo_data = B2;
    tick();
    check("pkt_b2_valid", 32'(bus.ovalid),  32'd1);
    check("pkt_b2_data",  bus.odata,        B2);
    check("pkt_b2_cred",  32'(bus.credits), 32'd1);
    bus.fifo_data = T;
    tick();
    check("pkt_t_valid", 32'(bus.ovalid),  32'd1);
    check("pkt_t_data",  bus.odata,        T);
    check("pkt_t_cred",  32'(bus.credits), 32'd0);
    check("pkt_t_inpkt", 32'(bus.in_pkt),  32'd0);

    // Out of credits: stalled; a returned credit only allows sending next cycle
    bus.fifo_data = HT;
    bus.icredit   = 1'b1;
    #1;
    check("starve_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    check("starve_valid", 32'(bus.ovalid),  32'd0);
    check("starve_odata", bus.odata,        32'd0);
    check("starve_cred1", 32'(bus.credits), 32'd1);
    bus.icredit = 1'b0;
    #1;
    check("resume_rd_en", 32'(bus.fifo_rd_en), 32'd1);
    tick();
    check("resume_valid", 32'(bus.ovalid),  32'd1);
    check("resume_data",  bus.odata,        HT);
    check("resume_cred",  32'(bus.credits), 32'd0);

    // Refill to 2, then send and return a credit together for 5 cycles
    bus.fifo_empty = 1'b1;
    bus.icredit    = 1'b1;
    tick(); tick();
    check("refill2_cred", 32'(bus.credits), 32'd2);
    bus.fifo_empty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = {2'b11, 30'(32'h100 + i)};
      bus.fifo_data = d;
      tick();
      check("bal_valid", 32'(bus.ovalid),  32'd1);
      check("bal_data",  bus.odata,        d);
      check("bal_cred",  32'(bus.credits), 32'd2);
    end

    // Refill to full, then an excess credit is dropped
    bus.fifo_empty = 1'b1;
    tick(); tick();
    check("full_cred", 32'(bus.credits), 32'd4);
`ifdef TX_CREDIT_CHECK_EN
    check("full_cerr_clear", 32'(cerr), 32'd0);
`endif
    tick();
    check("ovf_cred", 32'(bus.credits), 32'd4);
`ifdef TX_CREDIT_CHECK_EN
    check("ovf_cerr", 32'(cerr), 32'd1);
`endif
    bus.icredit = 1'b0;
    tick();
    check("ovf_cred_hold", 32'(bus.credits), 32'd4);
    check("ovf_valid",     32'(bus.ovalid),  32'd0);
`ifdef TX_CREDIT_CHECK_EN
    check("ovf_cerr_sticky", 32'(cerr), 32'd1);
`endif

    // Reset mid-packet abandons it
    bus.fifo_empty = 1'b0;
    bus.fifo_data  = H;
    tick();
    check("mid_h_inpkt", 32'(bus.in_pkt),  32'd1);
    check("mid_h_cred",  32'(bus.credits), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    tick();
    check("mid_rst_inpkt", 32'(bus.in_pkt),  32'd0);
    check("mid_rst_cred",  32'(bus.credits), 32'd4);
    check("mid_rst_valid", 32'(bus.ovalid),  32'd0);
`ifdef TX_CREDIT_CHECK_EN
    check("mid_rst_cerr", 32'(cerr), 32'd0);
`endif
    rst = 1'b0;
    bus.fifo_data = HT;
    tick();
    check("post_ht_valid", 32'(bus.ovalid),  32'd1);
    check("post_ht_data",  bus.odata,        HT);
    check("post_ht_inpkt", 32'(bus.in_pkt),  32'd0);
    check("post_ht_cred",  32'(bus.credits), 32'd3);

    // Body while idle is still forwarded and leaves the port idle
    bus.fifo_data = B1;
    tick();
    check("orphan_data",  bus.odata,        B1);
    check("orphan_inpkt", 32'(bus.in_pkt),  32'd0);
    check("orphan_cred",  32'(bus.credits), 32'd2);
`ifdef TX_CREDIT_CHECK_EN
    check("orphan_cerr", 32'(cerr), 32'd1);
`endif
    bus.fifo_empty = 1'b1;
    tick();
    check("drain_valid", 32'(bus.ovalid), 32'd0);
    check("drain_odata", bus.odata,       32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_port.md
TX_PORT -- requirements
Module: tx_port

Interface
REQ-001 SHALL have parameter DATAW, default 31, meaning flit MSB index (flit width DATAW+1).
REQ-002 SHALL have parameter CRED, default 4, meaning downstream receive-FIFO capacity in flits (initial credit count).
REQ-003 SHALL have parameter CNTW, default 3, meaning credit counter width; CRED SHALL fit in CNTW bits.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port fifo_data  input  DATAW+1  head flit of local FIFO; bits [DATAW:DATAW-1] = type (01 head, 00 body, 10 tail, 11 head+tail).
REQ-007 SHALL have port fifo_empty  input  1  local FIFO has no flit.
REQ-008 SHALL have port fifo_rd_en  output  1  pop local FIFO this cycle.
REQ-009 SHALL have port odata  output  DATAW+1  flit to downstream link.
REQ-010 SHALL have port ovalid  output  1  odata carries a valid flit this cycle.
REQ-011 SHALL have port icredit  input  1  downstream freed one FIFO slot (one credit per cycle max).
REQ-012 SHALL have port credits  output  CNTW  current available credit count.
REQ-013 SHALL have port in_pkt  output  1  packet in progress (head sent, tail not yet sent).

Function
REQ-014 Send condition SHALL be send = ~fifo_empty & (credits != 0), combinational.
REQ-015 fifo_rd_en SHALL equal send in the same cycle.
REQ-016 On send, odata SHALL register fifo_data and ovalid SHALL be 1 on the next cycle (latency 1).
REQ-017 Without send, ovalid SHALL be 0 the next cycle and odata SHALL be 0.
REQ-018 Credit update per cycle: credits_next = credits + icredit - send, in CNTW-bit arithmetic.
REQ-019 Simultaneous send and icredit SHALL leave credits unchanged.
REQ-020 With credits == 0 and icredit == 1, send SHALL stay 0 that cycle; sending resumes next cycle.
REQ-021 icredit with credits == CRED (overflow) SHALL be ignored; credits SHALL saturate at CRED.
REQ-022 FSM states IDLE and ACTIVE; in_pkt = 1 exactly in ACTIVE.
REQ-023 IDLE -> ACTIVE on send of type 01; IDLE stays on type 11 send.
REQ-024 ACTIVE -> IDLE on send of type 10; ACTIVE stays on type 00.
REQ-025 Body or tail sent in IDLE, or head/head+tail sent in ACTIVE, SHALL still be forwarded unchanged; state per REQ-023/024 using type bits only (tail always -> IDLE, head always -> ACTIVE).
REQ-026 Back-to-back sends SHALL sustain one flit per cycle while credits and data are available.

Reset
REQ-027 While rst = 1 at a clock edge: credits <= CRED, state <= IDLE, odata <= 0, ovalid <= 0.
REQ-028 fifo_rd_en SHALL be 0 during any cycle rst = 1; icredit SHALL be ignored.
REQ-029 Reset asserted mid-packet SHALL abandon the packet; no flit is sent after reset until a new send condition.

Configuration
REQ-030 Macro TX_CREDIT_CHECK_EN SHALL, when defined, add output cerr (1 bit), sticky, set on the edge after an icredit received with credits == CRED and send == 0, and after any protocol violation of REQ-025; cleared only by rst.
REQ-031 Without TX_CREDIT_CHECK_EN, port cerr and its logic SHALL be absent; REQ-021 saturation behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset, CRED=4: after rst, credits=4, ovalid=0, in_pkt=0, fifo_rd_en=0 with fifo_empty=0 during rst.
REQ-033 FIFO holds head,body,body,tail, no icredit: four consecutive sends, ovalid=1 cycles 1-4, credits 4->0, in_pkt 1 after head, 0 after tail.
REQ-034 Credits=0, fifo non-empty: fifo_rd_en=0; pulse icredit -> credits=1 next cycle, one flit sent following cycle, credits back to 0.
REQ-035 Credits=2, send and icredit same cycle for 5 cycles: credits remain 2, five flits emitted in order.
REQ-036 Credits=4, icredit=1, no send: credits stay 4; with TX_CREDIT_CHECK_EN cerr=1 next cycle and persists until rst.
REQ-037 rst asserted after head sent: next cycle in_pkt=0, credits=4, ovalid=0; subsequent head+tail flit sends with in_pkt staying 0.
